seq_playback_ctrl: RTL and testbench
====================================

// Module: seq_playback_ctrl
// PURPOSE
//   Sequences playback of the stored colour sequence onto the four key LEDs for the memory game.
//   On start it reads entries 0..len-1 from the sequence store over a 1-cycle-latency read port.
//   It shows each entry one-hot for ON_TICKS ticks, then blanks the LEDs for GAP_TICKS ticks.
//   Sits between the game FSM (start/len/abort/done) and the sequence store / LED mux; timing comes from the clock-divider tick.
// PARAMETERS
//   MAX_LEN    100  deepest sequence entry count; len is clamped to this
//   ADDR_W     7    sequence store address width (covers MAX_LEN-1)
//   ON_TICKS   32   ticks each entry's LED stays lit (>=1)
//   GAP_TICKS  8    ticks of dark LEDs after each entry (>=1)
//   CNT_W      8    tick counter width (must hold max(ON_TICKS,GAP_TICKS))
// PORTS
//   clk       in   1       system clock; the only clock
//   rst       in   1       synchronous, active-high reset
//   tick      in   1       one-cycle enable pulse from clock divider; paces ON/GAP timing
//   start     in   1       request playback; sampled only in IDLE
//   len       in   8       number of entries to play (round number), captured with start
//   abort     in   1       cancel playback immediately
//   mem_addr  out  ADDR_W  sequence store read address
//   mem_data  in   2       colour at mem_addr, valid one clk after mem_addr changes
//   key_leds  out  4       one-hot LED drive: 00->0001, 01->0010, 10->0100, 11->1000
//   busy      out  1       high from accepted start until return to IDLE
//   done      out  1       one-cycle pulse when playback completes normally
//   step      out  ADDR_W  index of the entry currently being fetched or shown
// BEHAVIOUR
//   - All outputs registered. After rst: state IDLE, key_leds=0, mem_addr=0, step=0, busy=0, done=0, counter=0.
//   - States: IDLE, FETCH, WAIT, SHOW, GAP, FINISH.
//   - IDLE: start=1 and abort=0 -> latch L=min(len,MAX_LEN); step=0, mem_addr=0, busy=1.
//     If L=0 go to FINISH, otherwise go to FETCH.
//   - FETCH (1 clk): mem_addr=step -> WAIT.
//   - WAIT (1 clk): capture mem_data as colour; counter=0 -> SHOW.
//   - SHOW: key_leds=onehot(colour). Each tick increments the counter.
//     On the tick with counter==ON_TICKS-1: key_leds=0, counter=0 -> GAP.
//   - GAP: key_leds=0. On the tick with counter==GAP_TICKS-1:
//     step+1==L -> FINISH; else step=step+1 -> FETCH.
//   - FINISH (1 clk): done=1, busy=0 -> IDLE. done is low in every other cycle.
//   - Latency: start sampled at edge N -> busy=1 and mem_addr=0 after N; colour captured at N+2; key_leds lit after N+2.
//   - Ticks in IDLE, FETCH, WAIT and FINISH are ignored. Tick pulses in SHOW/GAP are counted only when tick=1; counter never wraps.
//   - start while busy: ignored; len is not re-sampled.
//   - abort in any non-IDLE state: next edge -> IDLE, key_leds=0, busy=0, step=0, no done pulse.
//   - abort and start together in IDLE: abort wins, start is dropped.
//   - len>MAX_LEN: plays exactly MAX_LEN entries. step never exceeds L-1.
//   - rst mid-playback: same result as abort, plus every output returns to its reset value on that edge.
//   - Exactly one key_leds bit is high in SHOW; key_leds=0 in all other states.
// TESTING
//   (bench: ON_TICKS=2, GAP_TICKS=1, tick tied high unless noted; store holds [2,0,3,1,...])
//   1. start, len=3 -> key_leds 0100,0100,0000,0001,0001,0000,1000,1000,0000; then done pulse 1 clk; busy falls with done.
//   2. start, len=0 -> busy high 1 clk, done pulse on the next edge, key_leds never nonzero, mem reads only addr 0.
//   3. start, len=200 -> exactly 100 SHOW phases; step peaks at 99; done pulses once.
//   4. abort during the 2nd SHOW of len=3 -> key_leds=0, busy=0 next clk; done never asserts; a new start replays from step 0.
//   5. tick every 4th clk, len=1 -> SHOW spans 2 ticks, GAP spans 1 tick; start re-pulsed mid-play has no effect.
//   6. rst asserted in GAP, or start+abort together in IDLE -> all outputs at reset values next clk; state IDLE.

Source files
------------

// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl: plays the stored colour sequence onto the four key LEDs with ON/GAP tick pacing
//   clk, rst        system clock, synchronous active-high reset
//   tick            clock-divider enable pulse that paces the ON and GAP phases
//   start, len      playback request and entry count (clamped to MAX_LEN), sampled only in IDLE
//   abort           cancels playback on the next edge without a done pulse
//   mem_addr        sequence store read address
//   mem_data        store output, valid one clk after mem_addr changes
//   key_leds        one-hot colour while an entry is shown, dark otherwise
//   busy, done      playback active; one-cycle completion pulse
//   step            index of the entry being fetched or shown
module seq_playback_ctrl #(
    parameter int MAX_LEN   = 100,
    parameter int ADDR_W    = 7,
    parameter int ON_TICKS  = 32,
    parameter int GAP_TICKS = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        key_leds,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHOW, S_GAP, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d, len_clamp, step_nx;
    logic [ADDR_W-1:0] step_q, step_d, mem_addr_q, mem_addr_d;
    logic [3:0]        key_leds_q, key_leds_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign len_clamp = (len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len;
    assign step_nx   = 8'(step_q) + 8'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        step_d     = step_q;
        mem_addr_d = mem_addr_q;
        key_leds_d = key_leds_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        if (abort) begin
            state_d    = S_IDLE;
            step_d     = '0;
            mem_addr_d = '0;
            key_leds_d = '0;
            busy_d     = 1'b0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    len_d      = len_clamp;
                    step_d     = '0;
                    mem_addr_d = '0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = (len_clamp == 8'd0) ? S_FINISH : S_FETCH;
                end
                S_FETCH: begin
                    mem_addr_d = step_q;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    key_leds_d = 4'b0001 << mem_data;
                    cnt_d      = '0;
                    state_d    = S_SHOW;
                end
                S_SHOW: if (tick) begin
                    if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                        key_leds_d = '0;
                        cnt_d      = '0;
                        state_d    = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: if (tick) begin
                    if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_d = '0;
                        if (step_nx == len_q) begin
                            state_d = S_FINISH;
                        end else begin
                            // Address moves with step so the store has a full clk before WAIT samples it.
                            step_d     = step_nx[ADDR_W-1:0];
                            mem_addr_d = step_nx[ADDR_W-1:0];
                            state_d    = S_FETCH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            step_q     <= '0;
            mem_addr_q <= '0;
            key_leds_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            step_q     <= step_d;
            mem_addr_q <= mem_addr_d;
            key_leds_q <= key_leds_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign key_leds = key_leds_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step     = step_q;
endmodule

// File: tb/tb_seq_playback_ctrl.sv
// tb_seq_playback_ctrl: drives playbacks against a tick-counting timeline model of the LED sequence
module tb_seq_playback_ctrl;
    localparam int MAXC = 2048;
    localparam int ON   = 2;
    localparam int GP   = 1;

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] len = 8'd0;
    logic [6:0] mem_addr, step;
    logic [1:0] mem_data;
    logic [3:0] key_leds;
    logic       busy, done;

    logic [1:0] store [0:127];
    bit         tk [0:MAXC];
    logic [3:0] e_leds [0:MAXC];
    bit         e_busy [0:MAXC];
    bit         e_done [0:MAXC];
    int         e_step [0:MAXC];
    int         n_checks = 0, n_fail = 0, n_show, n_done, max_step;

    seq_playback_ctrl #(
        .MAX_LEN(100), .ADDR_W(7), .ON_TICKS(ON), .GAP_TICKS(GP), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .len(len), .abort(abort),
        .mem_addr(mem_addr), .mem_data(mem_data), .key_leds(key_leds),
        .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= store[mem_addr];

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // Expected timeline: entry i starts at cycle t, is lit from t+2 until the edge carrying the
    // ON-th tick counted after it lit, then dark until the GP-th further tick; done follows the last.
    task automatic play(input int lin, input int mode, input int kill_at, input bit kill_rst, input int restart_at);
        int  L, t, e, n, fin, last;
        bit  lit;
        L = (lin > 100) ? 100 : lin;
        for (int c = 0; c <= MAXC; c++) begin
            tk[c]     = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 3) : 1'($urandom_range(0, 1));
            e_leds[c] = 4'd0;
            e_busy[c] = 1'b1;
            e_done[c] = 1'b0;
            e_step[c] = 0;
        end
        t = 0;
        for (int i = 0; i < L; i++) begin
            for (int c = t; c <= MAXC; c++) e_step[c] = i;
            e = t + 2;
            n = 0;
            while (n < ON && e < MAXC - 8) begin e++; n += int'(tk[e]); end
            for (int c = t + 2; c < e; c++) e_leds[c] = 4'b0001 << store[i];
            n = 0;
            while (n < GP && e < MAXC - 8) begin e++; n += int'(tk[e]); end
            t = e;
        end
        fin = t + 1;
        for (int c = fin; c <= MAXC; c++) e_busy[c] = 1'b0;
        e_done[fin] = 1'b1;
        last = fin + 1;
        if (kill_at >= 0) begin
            for (int c = kill_at; c <= MAXC; c++) begin
                e_leds[c] = 4'd0;
                e_busy[c] = 1'b0;
                e_done[c] = 1'b0;
                e_step[c] = 0;
            end
            last = kill_at + 1;
        end
        n_show = 0; n_done = 0; max_step = 0; lit = 1'b0;
        start = 1'b1; len = 8'(lin); tick = tk[0]; abort = 1'b0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            check("outputs", c, {key_leds, busy, done, step, mem_addr},
                  {e_leds[c], e_busy[c], e_done[c], 7'(e_step[c]), 7'(e_step[c])});
            if (key_leds != 4'd0 && !lit) n_show++;
            lit = (key_leds != 4'd0);
            if (int'(step) > max_step) max_step = int'(step);
            n_done += int'(done);
            start = (c + 1 == restart_at);
            len   = 8'd50;
            tick  = tk[c + 1];
            abort = !kill_rst && (c + 1 == kill_at);
            rst   = kill_rst && (c + 1 == kill_at);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) store[i] = 2'($urandom_range(0, 3));
        store[0] = 2'd2; store[1] = 2'd0; store[2] = 2'd3; store[3] = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, {key_leds, busy, done, step, mem_addr}, 32'd0);
        rst = 1'b0;

        play(3, 0, -1, 1'b0, -1);
        check("len3_shows", 0, n_show, 3);
        check("len3_done", 0, n_done, 1);

        start = 1'b1; abort = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        check("start_abort_idle", 0, {key_leds, busy, done, step, mem_addr}, 32'd0);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("start_dropped", 1, {key_leds, busy, done, step, mem_addr}, 32'd0);

        play(0, 0, -1, 1'b0, -1);
        check("len0_dark", 0, n_show, 0);

        play(200, 0, -1, 1'b0, -1);
        check("clamp_shows", 0, n_show, 100);
        check("clamp_step_peak", 0, max_step, 99);
        check("clamp_done", 0, n_done, 1);

        play(3, 0, 8, 1'b0, -1);
        check("abort_no_done", 0, n_done, 0);
        play(3, 0, -1, 1'b0, -1);
        check("replay_shows", 0, n_show, 3);

        play(1, 1, -1, 1'b0, 4);
        check("slow_tick_shows", 0, n_show, 1);
        check("slow_tick_done", 0, n_done, 1);

        play(3, 0, 5, 1'b1, -1);
        check("rst_gap_no_done", 0, n_done, 0);

        for (int k = 0; k < 6; k++) play($urandom_range(0, 40), 2, -1, 1'b0, -1);
        play(20, 2, $urandom_range(3, 40), 1'b0, -1);
        play(5, 2, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
